// File: rtl/id_exe_stage_reg_pkg.sv
// Shared pipeline definitions used by the ID/EXE stage register and the
// stages around it: datapath width, ALU command encodings, enable
// polarity constants and barrel-shifter shift-type encodings.
package id_exe_stage_reg_pkg;

    localparam int REGISTER_LEN      = 32;
    localparam int SHIFT_OPERAND_LEN = 12;
    localparam int IMM24_LEN         = 24;
    localparam int REG_ADDR_LEN      = 4;
    localparam int EXE_CMD_LEN       = 4;
    localparam int STATUS_LEN        = 4;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    // ALU commands. Several opcodes share an encoding (CMP/SUB, TST/AND,
    // LDR/STR/ADD), so these are plain constants rather than an enum.
    localparam logic [EXE_CMD_LEN-1:0] EXE_NOP = 4'b0000;
    localparam logic [EXE_CMD_LEN-1:0] EXE_MOV = 4'b0001;
    localparam logic [EXE_CMD_LEN-1:0] EXE_ADD = 4'b0010;
    localparam logic [EXE_CMD_LEN-1:0] EXE_ADC = 4'b0011;
    localparam logic [EXE_CMD_LEN-1:0] EXE_SUB = 4'b0100;
    localparam logic [EXE_CMD_LEN-1:0] EXE_SBC = 4'b0101;
    localparam logic [EXE_CMD_LEN-1:0] EXE_AND = 4'b0110;
    localparam logic [EXE_CMD_LEN-1:0] EXE_ORR = 4'b0111;
    localparam logic [EXE_CMD_LEN-1:0] EXE_EOR = 4'b1000;
    localparam logic [EXE_CMD_LEN-1:0] EXE_MVN = 4'b1001;
    localparam logic [EXE_CMD_LEN-1:0] EXE_CMP = 4'b0100;
    localparam logic [EXE_CMD_LEN-1:0] EXE_TST = 4'b0110;
    localparam logic [EXE_CMD_LEN-1:0] EXE_LDR = 4'b0010;
    localparam logic [EXE_CMD_LEN-1:0] EXE_STR = 4'b0010;

    typedef enum logic [1:0] {
        SHIFT_LSL = 2'b00,
        SHIFT_LSR = 2'b01,
        SHIFT_ASR = 2'b10,
        SHIFT_ROR = 2'b11
    } shift_type_e;

endpackage

// File: rtl/id_exe_stage_reg_pipe_reg.sv
// Generic pipeline register with async active-high reset, synchronous
// clear (highest priority after reset) and load enable.
//   clk, rst : clock and async reset
//   clr_i    : synchronous clear to zero
//   en_i     : load d_i when high, hold otherwise
//   d_i/q_o  : WIDTH-bit data in / registered data out
module pipe_reg #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_o <= '0;
        end else if (clr_i) begin
            q_o <= '0;
        end else if (en_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/id_exe_stage_reg.sv
// ID/EXE pipeline stage register. Captures the decoded instruction fields
// from ID each cycle; flush squashes the stage to an all-zero bubble,
// freeze holds it. Control strobes are forced low for non-valid
// instructions, and a simultaneous memory read+write resolves to write.
// Ports: clk, rst (async, active-high), flush, freeze, one *_in per field,
// matching registered *_out, plus valid_in/valid_out.
module id_exe_stage_reg #(
    parameter int REGISTER_LEN = id_exe_stage_reg_pkg::REGISTER_LEN
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    freeze,
    input  logic                    valid_in,
    input  logic [REGISTER_LEN-1:0] pc_in,
    input  logic [REGISTER_LEN-1:0] val_rn_in,
    input  logic [REGISTER_LEN-1:0] val_rm_in,
    input  logic [11:0]             shift_operand_in,
    input  logic                    imm_in,
    input  logic [23:0]             signed_imm24_in,
    input  logic [3:0]              exe_cmd_in,
    input  logic                    mem_r_en_in,
    input  logic                    mem_w_en_in,
    input  logic                    wb_en_in,
    input  logic                    b_in,
    input  logic                    s_in,
    input  logic [3:0]              dest_in,
    input  logic [3:0]              src1_in,
    input  logic [3:0]              src2_in,
    input  logic [3:0]              status_in,
    output logic                    valid_out,
    output logic [REGISTER_LEN-1:0] pc_out,
    output logic [REGISTER_LEN-1:0] val_rn_out,
    output logic [REGISTER_LEN-1:0] val_rm_out,
    output logic [11:0]             shift_operand_out,
    output logic                    imm_out,
    output logic [23:0]             signed_imm24_out,
    output logic [3:0]              exe_cmd_out,
    output logic                    mem_r_en_out,
    output logic                    mem_w_en_out,
    output logic                    wb_en_out,
    output logic                    b_out,
    output logic                    s_out,
    output logic [3:0]              dest_out,
    output logic [3:0]              src1_out,
    output logic [3:0]              src2_out,
    output logic [3:0]              status_out
);

    import id_exe_stage_reg_pkg::*;

    localparam int STAGE_W = 3 * REGISTER_LEN + SHIFT_OPERAND_LEN + 1 + IMM24_LEN
                           + EXE_CMD_LEN + 5 + 3 * REG_ADDR_LEN + STATUS_LEN + 1;

    logic               mem_r_en_d;
    logic               mem_w_en_d;
    logic               wb_en_d;
    logic               b_d;
    logic               s_d;
    logic [STAGE_W-1:0] stage_d;
    logic [STAGE_W-1:0] stage_q;

    // Bubbles never carry live strobes; write beats read on a conflict.
    assign mem_w_en_d = valid_in & mem_w_en_in;
    assign mem_r_en_d = valid_in & mem_r_en_in & ~mem_w_en_in;
    assign wb_en_d    = valid_in & wb_en_in;
    assign b_d        = valid_in & b_in;
    assign s_d        = valid_in & s_in;

    assign stage_d = {pc_in, val_rn_in, val_rm_in, shift_operand_in, imm_in,
                      signed_imm24_in, exe_cmd_in, mem_r_en_d, mem_w_en_d,
                      wb_en_d, b_d, s_d, dest_in, src1_in, src2_in,
                      status_in, valid_in};

    // Flush is the clear input so it overrides freeze inside pipe_reg.
    pipe_reg #(
        .WIDTH (STAGE_W)
    ) u_stage (
        .clk   (clk),
        .rst   (rst),
        .clr_i (flush),
        .en_i  (freeze == DISABLE),
        .d_i   (stage_d),
        .q_o   (stage_q)
    );

    assign {pc_out, val_rn_out, val_rm_out, shift_operand_out, imm_out,
            signed_imm24_out, exe_cmd_out, mem_r_en_out, mem_w_en_out,
            wb_en_out, b_out, s_out, dest_out, src1_out, src2_out,
            status_out, valid_out} = stage_q;

endmodule

// File: doc/id_exe_stage_reg.md
ID_EXE_STAGE_REG -- requirements
Module: id_exe_stage_reg

Interface
REQ-001 Parameter REGISTER_LEN, default 32, datapath word width (PC, Val_Rn, Val_Rm).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 flush  input  1  branch-taken squash; inserts bubble.
REQ-005 freeze  input  1  hazard stall; holds contents.
REQ-006 pc_in  input  REGISTER_LEN  PC of instruction in ID.
REQ-007 val_rn_in / val_rm_in  input  REGISTER_LEN each  register-file read data for Rn and Rm.
REQ-008 shift_operand_in  input  12  instruction bits [11:0], consumed by EXE val2 generation.
REQ-009 imm_in  input  1  I bit; signed_imm24_in  input  24  branch offset.
REQ-010 exe_cmd_in  input  4  ALU command; mem_r_en_in, mem_w_en_in, wb_en_in, b_in, s_in  input  1 each.
REQ-011 dest_in, src1_in, src2_in  input  4 each  register numbers; status_in  input  4  NZCV flags.
REQ-012 One registered output per input field, same width, suffix _out; plus valid_out  output  1  stage holds a real instruction.
REQ-013 valid_in  input  1  ID stage presents a real instruction.

Function
REQ-014 Priority per rising edge: flush > freeze > load.
REQ-015 Load (flush=0, freeze=0): every _out takes its _in value; valid_out <= valid_in; latency exactly one cycle.
REQ-016 Freeze (flush=0, freeze=1): every output, including valid_out, SHALL hold its previous value.
REQ-017 Flush (flush=1, freeze any): mem_r_en, mem_w_en, wb_en, b, s, valid SHALL clear to 0 and exe_cmd to 4'b0000; datapath fields (pc, val_rn, val_rm, shift_operand, imm, signed_imm24, dest, src1, src2, status) SHALL clear to 0.
REQ-018 Bubble guard: on load with valid_in=0, control outputs (mem_r_en, mem_w_en, wb_en, b, s) SHALL be captured as 0 regardless of their inputs; datapath fields load normally.
REQ-019 mem_r_en_out and mem_w_en_out SHALL never both be 1; if both inputs are 1 on a valid load, mem_w_en wins and mem_r_en_out is 0.
REQ-020 No combinational path from any input to any output.
REQ-021 Fields are stored unmodified: no sign extension, shifting, or rotation of shift_operand/imm; the downstream val2 stage owns that.

Reset
REQ-022 rst=1 SHALL immediately (without a clock edge) force every output to 0, including valid_out and exe_cmd_out.
REQ-023 rst asserted mid-freeze or mid-flush SHALL override both; first rising edge after rst deassertion follows REQ-014.
REQ-024 No output SHALL be X after reset with any input pattern.

Structure
REQ-025 REGISTER_LEN, exe_cmd encodings, ENABLE/DISABLE constants, and the shift-type encodings SHALL live in the shared defines package, not locally.
REQ-026 One sub-module is natural: pipe_reg (parameterised width, async-high rst, clr, en), instantiated once per field or once for a concatenated bus.

Verification
REQ-027 rst pulsed for 3 ns between edges with outputs loaded non-zero -> all outputs 0 before the next edge.
REQ-028 Load pc_in=32'h0000_0010, val_rm_in=32'hDEAD_BEEF, shift_operand_in=12'h3C4, imm_in=1, wb_en_in=1, valid_in=1 -> identical values on outputs one edge later, valid_out=1.
REQ-029 freeze=1 for 3 cycles while inputs change every cycle -> outputs stay at the pre-freeze values; on freeze=0 the current inputs load on the next edge.
REQ-030 flush=1 and freeze=1 same cycle with mem_w_en_in=1, valid_in=1 -> after edge all outputs 0, valid_out=0.
REQ-031 valid_in=0 with wb_en_in=1, mem_r_en_in=1, val_rn_in=32'h1234_5678 -> wb_en_out=0, mem_r_en_out=0, val_rn_out=32'h1234_5678.
REQ-032 mem_r_en_in=1, mem_w_en_in=1, valid_in=1 -> mem_w_en_out=1, mem_r_en_out=0.
